// File: rtl/la_pwr_pkg.sv
// Shared types for the la_pwrseq power-domain sequencer: FSM state encoding
// and the elaboration-time counter width check.
package la_pwr_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_UP,
    ST_WAIT_PG,
    ST_RST_REL,
    ST_ON,
    ST_ISO,
    ST_DN,
    ST_FAULT
  } state_e;

  // True when a cw-bit counter can hold the largest of the three limits.
  function automatic bit cw_fits(int unsigned cw, int unsigned step,
                                 int unsigned settle, int unsigned timeout);
    longint unsigned lim;
    int unsigned     m;
    m = step;
    if (settle > m)  m = settle;
    if (timeout > m) m = timeout;
    if (cw >= 63) return 1'b1;
    lim = (64'd1 << cw) - 64'd1;
    return (longint'(m) <= lim);
  endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-flop synchronizer for a single asynchronous level input.
module la_dsync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/la_pwrseq.sv
// Power-domain sequencer: staged switch enable, power-good settle, reset
// release and isolation removal, reversed on power-down, with req/ack handshake.
module la_pwrseq
  import la_pwr_pkg::*;
#(
  parameter     PROP    = "DEFAULT",
  parameter int N       = 4,
  parameter int STEP    = 8,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         req,
  output logic         ack,
  output logic         busy,
  output logic         fault,
  input  logic         pwr_good,
  output logic [N-1:0] sw_en,
  output logic         iso_en,
  output logic         dom_nreset
);

  if (!cw_fits(CW, STEP, SETTLE, TIMEOUT) || (N < 1)) begin : g_bad_cfg
    $error("la_pwrseq(%s): invalid N/CW configuration", PROP);
  end

  localparam logic [CW-1:0] STEP_M1   = CW'(STEP - 1);
  localparam logic [CW-1:0] SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [CW-1:0] TO_M1     = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  sw_en_q, sw_en_d;
  logic          iso_q, iso_d;
  logic          dnr_q, dnr_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic          pg_s;
  logic          to_fault;

  la_dsync u_pg_sync (
    .clk_i  (clk),
    .rst_ni (nreset),
    .d_i    (pwr_good),
    .q_o    (pg_s)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_OFF;
      sw_en_q <= '0;
      iso_q   <= 1'b1;
      dnr_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sw_en_q <= sw_en_d;
      iso_q   <= iso_d;
      dnr_q   <= dnr_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sw_en_d  = sw_en_q;
    iso_d    = iso_q;
    dnr_d    = dnr_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    scnt_d   = scnt_q;
    to_fault = 1'b0;

    case (state_q)
      ST_OFF: begin
        if (req) begin
          state_d = ST_UP;
          sw_en_d = N'(1);
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_UP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == STEP_M1) begin
          cnt_d = '0;
          // The last stage is held a full STEP before power-good is awaited.
          if (&sw_en_q) begin
            state_d = ST_WAIT_PG;
            tcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            sw_en_d = (sw_en_q << 1) | N'(1);
          end
        end
      end
      ST_WAIT_PG: begin
        tcnt_d = tcnt_q + CW'(1);
        scnt_d = pg_s ? scnt_q + CW'(1) : '0;
        if (pg_s && (scnt_q == SETTLE_M1)) begin
          state_d = ST_RST_REL;
          dnr_d   = 1'b1;
        end else if (tcnt_q == TO_M1) begin
          to_fault = 1'b1;
        end
      end
      ST_RST_REL: begin
        state_d = ST_ON;
        iso_d   = 1'b0;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
      end
      ST_ON: begin
        if (!req) begin
          state_d = ST_ISO;
          iso_d   = 1'b1;
          busy_d  = 1'b1;
        end else if (!pg_s) begin
          to_fault = 1'b1;
        end
      end
      ST_ISO: begin
        state_d = ST_DN;
        dnr_d   = 1'b0;
        cnt_d   = '0;
      end
      ST_DN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == STEP_M1) begin
          cnt_d   = '0;
          sw_en_d = sw_en_q >> 1;
          if ((sw_en_q >> 1) == '0) begin
            state_d = ST_OFF;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
          end
        end
      end
      ST_FAULT: begin
        if (!req) begin
          state_d = ST_OFF;
          fault_d = 1'b0;
        end
      end
      default: state_d = ST_OFF;
    endcase

    // Fault entry forces every domain control to its safe value in one edge.
    if (to_fault) begin
      state_d = ST_FAULT;
      sw_en_d = '0;
      iso_d   = 1'b1;
      dnr_d   = 1'b0;
      fault_d = 1'b1;
      ack_d   = 1'b0;
      busy_d  = 1'b0;
    end
  end

  assign sw_en      = sw_en_q;
  assign iso_en     = iso_q;
  assign dom_nreset = dnr_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_la_pwrseq.sv
// Scoreboard bench for la_pwrseq: expected output vectors are queued with the
// edge number at which they must appear and compared on the falling clock edge.
module tb_la_pwrseq;

  localparam int S  = 4;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       nreset;
  logic       req;
  logic       pwr_good;
  logic       ack, busy, fault, iso_en, dom_nreset;
  logic [3:0] sw_en;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [8:0]  exp;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  la_pwrseq #(
    .PROP    ("DEFAULT"),
    .N       (4),
    .STEP    (2),
    .SETTLE  (S),
    .TIMEOUT (TO),
    .CW      (8)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .req        (req),
    .ack        (ack),
    .busy       (busy),
    .fault      (fault),
    .pwr_good   (pwr_good),
    .sw_en      (sw_en),
    .iso_en     (iso_en),
    .dom_nreset (dom_nreset)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] outs();
    return {ack, busy, fault, iso_en, dom_nreset, sw_en};
  endfunction

  // {ack, busy, fault, iso_en, dom_nreset, sw_en}
  function automatic logic [8:0] ev(logic a, logic b, logic f, logic i, logic d,
                                    logic [3:0] sw);
    return {a, b, f, i, d, sw};
  endfunction

  task automatic push(input int unsigned c, input string tag, input logic [8:0] v);
    sb_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    int i = 0;
    do begin
      @(negedge clk);
      #1;
      i++;
    end while (sb.size() > 0 && i < 200);
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_edge(input int unsigned c);
    while (cyc < c) begin
      @(negedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic viol;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      check(e.tag, {23'd0, outs()}, {23'd0, e.exp});
    end
    viol = ((!dom_nreset || !(&sw_en)) && !iso_en) || (dom_nreset && !(&sw_en));
    check("invariant", {31'd0, viol}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0]  RST, ONV, FLT;
    int unsigned e0, e1, w;
    RST = ev(0, 0, 0, 1, 0, 4'b0000);
    ONV = ev(1, 0, 0, 0, 1, 4'b1111);
    FLT = ev(0, 0, 1, 1, 0, 4'b0000);

    nreset = 1'b0; req = 1'b0; pwr_good = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset", {23'd0, outs()}, {23'd0, RST});
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // Power-up with steady power-good
    e0 = cyc; req = 1'b1; w = e0 + 9;
    push(e0 + 1, "up_s0",    ev(0, 1, 0, 1, 0, 4'b0001));
    push(e0 + 2, "up_s0h",   ev(0, 1, 0, 1, 0, 4'b0001));
    push(e0 + 3, "up_s1",    ev(0, 1, 0, 1, 0, 4'b0011));
    push(e0 + 5, "up_s2",    ev(0, 1, 0, 1, 0, 4'b0111));
    push(e0 + 7, "up_s3",    ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + S - 1, "settle", ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + S, "rst_rel",    ev(0, 1, 0, 1, 1, 4'b1111));
    push(w + S + 1, "on",     ONV);
    push(w + S + 4, "on_hold", ONV);
    drain();

    // Power-down
    e1 = cyc; req = 1'b0;
    push(e1 + 1,  "iso",    ev(1, 1, 0, 1, 1, 4'b1111));
    push(e1 + 2,  "dn_rst", ev(1, 1, 0, 1, 0, 4'b1111));
    push(e1 + 4,  "dn_s3",  ev(1, 1, 0, 1, 0, 4'b0111));
    push(e1 + 6,  "dn_s2",  ev(1, 1, 0, 1, 0, 4'b0011));
    push(e1 + 8,  "dn_s1",  ev(1, 1, 0, 1, 0, 4'b0001));
    push(e1 + 9,  "dn_s1h", ev(1, 1, 0, 1, 0, 4'b0001));
    push(e1 + 10, "off",    RST);
    push(e1 + 13, "off_idle", RST);
    drain();

    // Power-good never arrives: timeout fault
    pwr_good = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    e0 = cyc; req = 1'b1; w = e0 + 9;
    push(e0 + 7, "to_s3",       ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + TO - 1, "to_pre",  ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + TO, "to_fault",    FLT);
    push(w + TO + 5, "to_hold", FLT);
    drain();
    e1 = cyc; req = 1'b0;
    push(e1 + 1, "to_clr", RST);
    drain();
    pwr_good = 1'b1;
    repeat (3) @(negedge clk);
    #1;

    // One-cycle power-good glitch during the settle window
    e0 = cyc; req = 1'b1; w = e0 + 9;
    push(w + S,     "gl_hold",  ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + S + 2, "gl_hold2", ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + S + 3, "gl_rel",   ev(0, 1, 0, 1, 1, 4'b1111));
    push(w + S + 4, "gl_on",    ONV);
    wait_edge(w);
    pwr_good = 1'b0;
    @(negedge clk);
    #1;
    pwr_good = 1'b1;
    drain();

    // Power lost while ON
    e1 = cyc; pwr_good = 1'b0;
    push(e1 + 2, "pl_on",    ONV);
    push(e1 + 3, "pl_fault", FLT);
    repeat (3) @(negedge clk);
    #1;
    pwr_good = 1'b1;
    drain();
    e1 = cyc; req = 1'b0;
    push(e1 + 1, "pl_clr", RST);
    drain();
    repeat (2) @(negedge clk);
    #1;

    // req dropped mid power-up: sequence completes, then powers down
    e0 = cyc; req = 1'b1; w = e0 + 9;
    push(e0 + 1, "m_s0", ev(0, 1, 0, 1, 0, 4'b0001));
    repeat (3) @(negedge clk);
    #1;
    req = 1'b0;
    push(e0 + 7, "m_s3",       ev(0, 1, 0, 1, 0, 4'b1111));
    push(w + S, "m_rel",       ev(0, 1, 0, 1, 1, 4'b1111));
    push(w + S + 1, "m_on",    ONV);
    push(w + S + 2, "m_iso",   ev(1, 1, 0, 1, 1, 4'b1111));
    push(w + S + 3, "m_dnrst", ev(1, 1, 0, 1, 0, 4'b1111));
    push(w + S + 11, "m_off",  RST);
    drain();

    // Reset asserted mid power-down
    e0 = cyc; req = 1'b1;
    push(e0 + 10 + S, "r_on", ONV);
    drain();
    e1 = cyc; req = 1'b0;
    wait_edge(e1 + 5);
    check("r_dn_pre", {23'd0, outs()}, {23'd0, ev(1, 1, 0, 1, 0, 4'b0111)});
    nreset = 1'b0;
    #1;
    check("rst_mid_dn", {23'd0, outs()}, {23'd0, RST});
    @(negedge clk);
    #1;
    nreset = 1'b1;
    push(cyc + 1, "idle_a", RST);
    push(cyc + 4, "idle_b", RST);
    drain();

    // Reset asserted mid power-up
    e0 = cyc; req = 1'b1;
    wait_edge(e0 + 4);
    check("r_up_pre", {23'd0, outs()}, {23'd0, ev(0, 1, 0, 1, 0, 4'b0011)});
    nreset = 1'b0;
    req = 1'b0;
    #1;
    check("rst_mid_up", {23'd0, outs()}, {23'd0, RST});
    @(negedge clk);
    #1;
    nreset = 1'b1;
    push(cyc + 1, "idle_c", RST);
    push(cyc + 5, "idle_d", RST);
    drain();
    e0 = cyc; req = 1'b1;
    push(e0 + 1, "re_s0", ev(0, 1, 0, 1, 0, 4'b0001));
    push(e0 + 3, "re_s1", ev(0, 1, 0, 1, 0, 4'b0011));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
